// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the unified memory-port
//               arbiter: FSM state encoding, requester identifiers and the
//               width of the memory latency counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Requester identifiers; the value doubles as the bit index into the
    // two-bit request/grant vectors handed to the round-robin arbiter.
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    // Latency counter width; sized for MEM_LATENCY up to 15.
    localparam int unsigned LAT_CNT_W = 4;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter. A lone requester always wins;
//               with both requesting, the one that did not win last time
//               is granted. Purely combinational; the caller keeps
//               last_grant up to date.
// Ports       : req[1:0]   - request vector (bit index = req_id_t value)
//               last_grant - requester that received the previous grant
//               enable     - grants are suppressed when low
//               gnt[1:0]   - one-hot grant (all zero when nothing wins)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    input  logic       enable,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Contention: hand the port to whoever was not served last.
                2'b11:   gnt = (last_grant == REQ_IF) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one fixed-latency memory port between instruction
//               fetch (IF) and data load/store (D). Round-robin grant,
//               one access in flight at a time, read data / store ack
//               returned to the winning requester. No new grants while the
//               CPU reports halt.
// Ports       : clk, rst (async, active high), halt
//               if_req/if_addr -> if_gnt, if_rvalid, if_rdata
//               d_req/d_we/d_addr/d_wdata/d_be -> d_gnt, d_rvalid, d_rdata
//               mem_en/mem_we/mem_addr/mem_wdata/mem_be -> memory command
//               mem_rdata <- memory read data, MEM_LATENCY after mem_en
//               busy - an access is in flight
// Timing      : gnt in cycle 0, rvalid in cycle MEM_LATENCY+1, next grant
//               possible in cycle MEM_LATENCY+2. MEM_LATENCY legal 1..15.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                halt,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    localparam int                   BE_W    = DATA_W / 8;
    localparam logic [LAT_CNT_W-1:0] LAT_LIM = LAT_CNT_W'(MEM_LATENCY);
    localparam logic [LAT_CNT_W-1:0] CNT_ONE = LAT_CNT_W'(1);

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    req_id_t              r_last_grant;
    req_id_t              r_owner;
    logic [LAT_CNT_W-1:0] r_cnt;

    logic                 r_mem_we;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wdata;
    logic [BE_W-1:0]      r_mem_be;

    logic [DATA_W-1:0]    r_if_rdata;
    logic [DATA_W-1:0]    r_d_rdata;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic       w_arb_en;
    logic [1:0] w_gnt;
    logic       w_grant_any;
    req_id_t    w_winner;
    logic       w_lat_done;

    // rst gates the enable so that a request held during reset can never
    // leak a combinational grant or memory strobe.
    assign w_arb_en    = (r_state == IDLE) && !halt && !rst;
    assign w_grant_any = |w_gnt;
    assign w_winner    = w_gnt[REQ_D] ? REQ_D : REQ_IF;
    assign w_lat_done  = (r_state == WAIT) && (r_cnt == LAT_LIM);

    rr_arbiter2 u_rr_arbiter2 (
        .req        ({d_req, if_req}),
        .last_grant (r_last_grant),
        .enable     (w_arb_en),
        .gnt        (w_gnt)
    );

    // ------------------------------------------------------------------
    // Memory command selection for the grant cycle
    // ------------------------------------------------------------------
    logic              w_cmd_we;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic [BE_W-1:0]   w_cmd_be;

    always_comb begin
        w_cmd_we   = 1'b0;
        w_cmd_addr = if_addr;
        w_cmd_be   = '1;
        if (w_winner == REQ_D) begin
            w_cmd_we   = d_we;
            w_cmd_addr = d_addr;
            // Loads read the whole word; only stores carry byte enables.
            if (d_we) begin
                w_cmd_be = d_be;
            end
        end
    end

    // The command is driven straight through in the grant cycle and the
    // registered copy holds it afterwards, so the memory sees a stable bus.
    assign mem_en    = w_grant_any;
    assign mem_we    = w_grant_any ? w_cmd_we   : r_mem_we;
    assign mem_addr  = w_grant_any ? w_cmd_addr : r_mem_addr;
    assign mem_wdata = w_grant_any ? d_wdata    : r_mem_wdata;
    assign mem_be    = w_grant_any ? w_cmd_be   : r_mem_be;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant_any) w_state_nxt = WAIT;
            WAIT:    if (w_lat_done)  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= REQ_IF;
            r_owner      <= REQ_IF;
            r_cnt        <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            if (w_grant_any) begin
                r_last_grant <= w_winner;
                r_owner      <= w_winner;
                // The grant cycle itself is latency cycle 0, so the first
                // WAIT cycle is cycle 1.
                r_cnt        <= CNT_ONE;
                r_mem_we     <= w_cmd_we;
                r_mem_addr   <= w_cmd_addr;
                r_mem_wdata  <= d_wdata;
                r_mem_be     <= w_cmd_be;
            end else if ((r_state == WAIT) && !w_lat_done) begin
                r_cnt <= r_cnt + CNT_ONE;
            end

            // Capture unconditionally on completion; for a store the word
            // is don't-care but keeps the capture path uniform.
            if (w_lat_done) begin
                if (r_owner == REQ_D) begin
                    r_d_rdata <= mem_rdata;
                end else begin
                    r_if_rdata <= mem_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign if_gnt    = w_gnt[REQ_IF];
    assign d_gnt     = w_gnt[REQ_D];
    assign if_rvalid = (r_state == RESP) && (r_owner == REQ_IF);
    assign d_rvalid  = (r_state == RESP) && (r_owner == REQ_D);
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign busy      = (r_state != IDLE);

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A reference model
//               tracks when the port is free, who should win, and what
//               each access returns; responses are queued on grant and
//               popped by a monitor when they fall due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int LAT = 2;
    localparam int MEM_WORDS = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          halt;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 16) return 32'h20080005;   // word at byte address 0x40
        return (32'(idx) * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Memory device: fixed latency, driven only by the DUT's command bus
    // ------------------------------------------------------------------
    logic [31:0] dev_mem [MEM_WORDS];
    logic [31:0] pipe    [LAT];
    assign mem_rdata = pipe[LAT-1];

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) dev_mem[i] = init_word(i);
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
    end

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= $urandom;
        if (mem_en) begin
            if (mem_we) dev_mem[mem_addr[11:2]] <= merge(dev_mem[mem_addr[11:2]], mem_wdata, mem_be);
            else        pipe[0] <= dev_mem[mem_addr[11:2]];
        end
    end

    // ------------------------------------------------------------------
    // Reference model + scoreboard monitor
    // ------------------------------------------------------------------
    typedef struct {
        bit          who;     // 0 = IF, 1 = D
        bit          we;
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] ref_mem [MEM_WORDS];
    int          free_at    = 0;
    bit          last_win   = 1'b0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_d_rdata  = '0;
    bit          d_known    = 1'b1;
    logic [31:0] m_mem_addr = '0;

    initial for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);

    always @(negedge clk) begin
        bit          exp_g, win, we, exp_ifv, exp_dv;
        logic [31:0] addr;
        resp_t       r;
        if (rst) begin
            sb.delete();
            free_at    = 0;
            last_win   = 1'b0;
            m_if_rdata = '0;
            m_d_rdata  = '0;
            d_known    = 1'b1;
            m_mem_addr = '0;
            chk("rst_if_gnt", 64'(if_gnt), 64'd0);
            chk("rst_d_gnt", 64'(d_gnt), 64'd0);
            chk("rst_mem_en", 64'(mem_en), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_rvalid", {62'd0, if_rvalid, d_rvalid}, 64'd0);
            chk("rst_rdata", {if_rdata, d_rdata}, 64'd0);
            chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        end else begin
            exp_g = (cyc >= free_at) && !halt && (if_req || d_req);
            win   = (if_req && d_req) ? ~last_win : d_req;
            chk("busy", 64'(busy), 64'(cyc < free_at));
            chk("if_gnt", 64'(if_gnt), 64'(exp_g && !win));
            chk("d_gnt", 64'(d_gnt), 64'(exp_g && win));
            chk("mem_en", 64'(mem_en), 64'(exp_g));
            if (exp_g) begin
                addr = win ? d_addr : if_addr;
                we   = win && d_we;
                chk("mem_addr", 64'(mem_addr), 64'(addr));
                chk("mem_we", 64'(mem_we), 64'(we));
                chk("mem_be", 64'(mem_be), 64'(we ? d_be : 4'hF));
                chk("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
                if (we) ref_mem[addr[11:2]] = merge(ref_mem[addr[11:2]], d_wdata, d_be);
                r.who  = win;
                r.we   = we;
                r.data = ref_mem[addr[11:2]];
                r.due  = cyc + LAT + 1;
                sb.push_back(r);
                free_at    = cyc + LAT + 2;
                last_win   = win;
                m_mem_addr = addr;
            end else begin
                chk("mem_addr_hold", 64'(mem_addr), 64'(m_mem_addr));
            end
            exp_ifv = 1'b0;
            exp_dv  = 1'b0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                r = sb.pop_front();
                if (r.who) begin
                    exp_dv = 1'b1;
                    if (r.we) d_known = 1'b0;
                    else begin
                        d_known   = 1'b1;
                        m_d_rdata = r.data;
                    end
                end else begin
                    exp_ifv    = 1'b1;
                    m_if_rdata = r.data;
                end
            end
            chk("if_rvalid", 64'(if_rvalid), 64'(exp_ifv));
            chk("d_rvalid", 64'(d_rvalid), 64'(exp_dv));
            chk("if_rdata", 64'(if_rdata), 64'(m_if_rdata));
            if (d_known) chk("d_rdata", 64'(d_rdata), 64'(m_d_rdata));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for any grant; returns winner (1 = D) and its cycle.
    task automatic wait_any(output bit who, output int gcyc);
        who  = 1'b0;
        gcyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                who  = d_gnt;
                gcyc = cyc;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL grant_timeout @cycle %0d: got no grant expected a grant", cyc);
    endtask

    initial begin
        bit who;
        int g, g0, rel;
        bit tif, td;

        rst = 1'b1; halt = 1'b0;
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;

        // Reset held with a pending fetch, then a fetch of 0x40
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rel = cyc;
        wait_any(who, g);
        chk("first_gnt_cycle", 64'(g), 64'(rel));
        chk("first_gnt_who", 64'(who), 64'd0);
        tick(); if_req = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1 chk("fetch_0x40", 64'(if_rdata), 64'h20080005);

        // Store with partial byte enables, then read it back
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        wait_any(who, g);
        tick(); d_req = 1'b0;
        repeat (LAT + 2) tick();
        d_req = 1'b1; d_we = 1'b0;
        wait_any(who, g);
        tick(); d_req = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1 chk("load_after_store", 64'(d_rdata), 64'(merge(init_word(64), 32'hDEADBEEF, 4'b0011)));

        // Both requesters held from reset: D, IF, D, IF every LAT+2 cycles
        tick(); rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h48;
        tick(); rst = 1'b0;
        g0 = 0;
        for (int k = 0; k < 4; k++) begin
            wait_any(who, g);
            if (k == 0) g0 = g;
            chk("alt_who", 64'(who), 64'((k % 2) == 0));
            chk("alt_cycle", 64'(g - g0), 64'(k * (LAT + 2)));
        end
        tick(); if_req = 1'b0; d_req = 1'b0;
        repeat (LAT + 3) tick();

        // Halt raised during a fetch with the request held
        if_req = 1'b1; if_addr = 32'h40;
        wait_any(who, g0);
        tick(); halt = 1'b1;
        repeat (5) tick();
        halt = 1'b0;
        wait_any(who, g);
        chk("halt_regrant_cycle", 64'(g - g0), 64'd6);
        chk("halt_regrant_who", 64'(who), 64'd0);
        tick(); if_req = 1'b0;
        repeat (LAT + 3) tick();

        // Reset in cycle 2 of a load; then a clean fetch
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        wait_any(who, g0);
        tick(); d_req = 1'b0;
        tick(); rst = 1'b1;
        #1 chk("busy_after_rst", 64'(busy), 64'd0);
        tick(); rst = 1'b0; if_req = 1'b1; if_addr = 32'h40;
        wait_any(who, g);
        tick(); if_req = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1 chk("post_rst_fetch", 64'(if_rdata), 64'h20080005);
        chk("post_rst_d_rdata", 64'(d_rdata), 64'd0);

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            tif = if_gnt;
            td  = d_gnt;
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            if (tif || !if_req) begin
                if_req  = (tif ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0));
                if_addr = 32'($urandom_range(0, 63)) << 2;
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            if (td || !d_req) begin
                d_req   = (td ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0));
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = 32'($urandom_range(0, 63)) << 2;
                d_wdata = $urandom;
                d_be    = 4'($urandom_range(1, 15));
            end else if ($urandom_range(0, 15) == 0) begin
                d_req = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) halt = ~halt;
        end

        tick();
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; halt = 1'b0;
        repeat (LAT + 4) tick();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog @cycle %0d: got no completion expected test end", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
